// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the count_ctrl run/pause/clear sequencer:
// state encoding, command set and the command-priority ordering.
package count_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_RUN   = ST_RUN,
      S_PAUSE = ST_PAUSE,
      S_DONE  = ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_START,
      CMD_STOP,
      CMD_TERM,
      CMD_CLR
   } cmd_e;

   // At most one command is acted on per cycle: clr > terminal tick > stop > start.
   function automatic cmd_e pick_cmd(input logic clr, input logic term,
                                     input logic stop, input logic start);
      cmd_e c;
      c = CMD_NONE;
      if (clr)
         c = CMD_CLR;
      else if (term)
         c = CMD_TERM;
      else if (stop)
         c = CMD_STOP;
      else if (start)
         c = CMD_START;
      return c;
   endfunction

endpackage

// File: rtl/count_ctrl_btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector: one raw
// asynchronous level in, one single-cycle pulse per press out.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic [1:0] sync_reg;
   logic       prev_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg <= 2'b00;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], btn};
         prev_reg <= sync_reg[1];
      end
   end

   assign pulse = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/count_ctrl.sv
// Run/pause/clear sequencer driving the enable and clear strobes of the shared up-counter.
// Build option COUNT_CTRL_AUTORELOAD_EN: terminal tick wraps the count instead of entering DONE.
module count_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH    = 7,
   parameter int TICK_DIV = 50000000,
   parameter int LIMIT    = 99
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_btn,
   input  logic             stop_btn,
   input  logic             clr_btn,
   input  logic [WIDTH-1:0] count_in,
   output logic             cnt_en,
   output logic             cnt_clr,
   output logic             running,
   output logic             done,
   output logic [1:0]       state
);

   localparam int             PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] LIMIT_VAL = WIDTH'(LIMIT);

   logic [2:0] btn_raw;
   logic [2:0] btn_pulse;
   logic       start_cmd;
   logic       stop_cmd;
   logic       clr_cmd;

   state_e        state_reg;
   logic [PW-1:0] presc_reg;
   logic          tick;
   logic          term_tick;
   cmd_e          cmd;

   assign btn_raw = {clr_btn, stop_btn, start_btn};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         btn_edge u_btn_edge (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_raw[gi]),
            .pulse (btn_pulse[gi])
         );
      end
   endgenerate

   assign start_cmd = btn_pulse[0];
   assign stop_cmd  = btn_pulse[1];
   assign clr_cmd   = btn_pulse[2];

   always_comb begin
      tick      = (state_reg == S_RUN) && (presc_reg == PRESC_LAST);
      term_tick = tick && (count_in == LIMIT_VAL);
      cmd       = pick_cmd(clr_cmd, term_tick, stop_cmd, start_cmd);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         presc_reg <= '0;
      end else begin
         if (state_reg == S_RUN)
            presc_reg <= tick ? '0 : presc_reg + 1'b1;

         case (cmd)
            CMD_CLR: begin
               state_reg <= S_IDLE;
               presc_reg <= '0;
            end
            CMD_TERM: begin
`ifdef COUNT_CTRL_AUTORELOAD_EN
               state_reg <= S_RUN;
`else
               state_reg <= S_DONE;
`endif
            end
            CMD_STOP: begin
               // A tick consumed on the stop cycle restarts the interval so resume does not double-count.
               if (state_reg == S_RUN) begin
                  state_reg <= S_PAUSE;
                  presc_reg <= tick ? '0 : presc_reg;
               end
            end
            CMD_START: begin
               case (state_reg)
                  S_IDLE: begin
                     state_reg <= S_RUN;
                     presc_reg <= '0;
                  end
                  S_PAUSE: state_reg <= S_RUN;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign cnt_en  = tick && (count_in != LIMIT_VAL);
   assign running = (state_reg == S_RUN);
   assign state   = state_reg;

`ifdef COUNT_CTRL_AUTORELOAD_EN
   assign cnt_clr = (cmd == CMD_CLR) || (cmd == CMD_TERM);
   assign done    = 1'b0;
`else
   assign cnt_clr = (cmd == CMD_CLR);
   assign done    = (state_reg == S_DONE);
`endif

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: behavioural model checked every cycle plus directed and random button traffic.
`timescale 1ns/1ps
module tb_count_ctrl;

   localparam int WIDTH    = 7;
   localparam int TICK_DIV = 4;
   localparam int LIMIT    = 5;
`ifdef COUNT_CTRL_AUTORELOAD_EN
   localparam bit AUTORELOAD = 1'b1;
`else
   localparam bit AUTORELOAD = 1'b0;
`endif

   logic             clk       = 1'b0;
   logic             rst       = 1'b0;
   logic             start_btn = 1'b0;
   logic             stop_btn  = 1'b0;
   logic             clr_btn   = 1'b0;
   logic [WIDTH-1:0] count_in  = '0;
   logic             cnt_en;
   logic             cnt_clr;
   logic             running;
   logic             done;
   logic [1:0]       state;

   int n_chk  = 0;
   int n_fail = 0;

   // model: state (0..3), prescaler phase, datapath count, button level history
   int       ms = 0;
   int       mp = 0;
   int       mc = 0;
   bit [3:0] h_start = '0;
   bit [3:0] h_stop  = '0;
   bit [3:0] h_clr   = '0;
   bit       done_seen = 1'b0;

   count_ctrl #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .LIMIT(LIMIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_btn (start_btn),
      .stop_btn  (stop_btn),
      .clr_btn   (clr_btn),
      .count_in  (count_in),
      .cnt_en    (cnt_en),
      .cnt_clr   (cnt_clr),
      .running   (running),
      .done      (done),
      .state     (state)
   );

   always #5 clk = ~clk;

   // counter datapath fed back into the controller
   always @(posedge clk) begin
      if (cnt_clr)
         count_in <= '0;
      else if (cnt_en)
         count_in <= count_in + 1'b1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare at the falling edge, then advance the model across the coming rising edge.
   always @(negedge clk) begin : model_proc
      bit c_start, c_stop, c_clr, tick, term, e_en, e_clr;
      if (!rst) begin
         chk("rst_cnt_en", cnt_en, 0);
         chk("rst_cnt_clr", cnt_clr, 0);
         chk("rst_running", running, 0);
         chk("rst_done", done, 0);
         chk("rst_state", state, 0);
         ms = 0;
         mp = 0;
         h_start = '0;
         h_stop  = '0;
         h_clr   = '0;
      end else begin
         h_start = {h_start[2:0], start_btn};
         h_stop  = {h_stop[2:0],  stop_btn};
         h_clr   = {h_clr[2:0],   clr_btn};
         // a level first seen two edges back becomes a command at the coming edge
         c_start = h_start[2] && !h_start[3];
         c_stop  = h_stop[2]  && !h_stop[3];
         c_clr   = h_clr[2]   && !h_clr[3];
         tick  = (ms == 1) && (mp == TICK_DIV - 1);
         term  = tick && (mc == LIMIT);
         e_en  = tick && (mc != LIMIT);
         e_clr = c_clr || (AUTORELOAD && term);
         chk("cnt_en", cnt_en, int'(e_en));
         chk("cnt_clr", cnt_clr, int'(e_clr));
         chk("running", running, int'(ms == 1));
         chk("done", done, int'(ms == 3));
         chk("state", state, ms);
         chk("count", count_in, mc);
         if (done) done_seen = 1'b1;

         if (c_clr) begin
            ms = 0; mp = 0;
         end else if (term) begin
            mp = 0;
            if (!AUTORELOAD) ms = 3;
         end else if (c_stop) begin
            if (ms == 1) begin
               ms = 2;
               if (tick) mp = 0;
            end
         end else if (c_start && ms == 0) begin
            ms = 1; mp = 0;
         end else if (c_start && ms == 2) begin
            ms = 1;
         end else if (ms == 1) begin
            mp = (mp + 1) % TICK_DIV;
         end

         if (e_clr) mc = 0;
         else if (e_en) mc = mc + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      @(posedge clk); #1 clr_btn = 1'b1;
      step(1); clr_btn = 1'b0;
      step(4);
   endtask

   task automatic press_start();
      @(posedge clk); #1 start_btn = 1'b1;
      step(1); start_btn = 1'b0;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit ok;
      int rem_start, rem_stop, rem_clr;

      // reset state
      step(3);
      chk("lit_reset_state", state, 0);
      chk("lit_reset_running", running, 0);
      chk("lit_reset_cnt_en", cnt_en, 0);
      rst = 1'b1;
      step(2);

      // start latency: acts on the third edge after the press
      @(posedge clk); #1 start_btn = 1'b1;
      @(posedge clk);
      step(1);
      chk("lit_start_k1", state, 0);
      step(1);
      chk("lit_start_k2", state, 1);
      chk("lit_start_running", running, 1);
      start_btn = 1'b0;
      step(3);
      chk("lit_first_tick", cnt_en, 1);

      // run to terminal
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (AUTORELOAD ? cnt_clr : done) begin ok = 1'b1; break; end
      end
      chk("wait_terminal", int'(ok), 1);
      if (!AUTORELOAD) begin
         chk("lit_term_state", state, 3);
         chk("lit_term_count", count_in, 5);
         step(20);
         chk("lit_hold_count", count_in, 5);
         chk("lit_hold_state", state, 3);
         press_start();
         step(5);
         chk("lit_start_in_done", state, 3);
      end else begin
         chk("lit_ar_state", state, 1);
         chk("lit_ar_count", count_in, 5);
         step(1);
         chk("lit_ar_wrap", count_in, 0);
         chk("lit_ar_still_run", state, 1);
      end
      clear_all();
      chk("lit_clr_state", state, 0);
      chk("lit_clr_count", count_in, 0);

      // pause with prescaler at 2, then resume
      press_start();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (ms == 1 && mp == 0) begin ok = 1'b1; break; end
      end
      chk("wait_presc0", int'(ok), 1);
      stop_btn = 1'b1;
      step(1); stop_btn = 1'b0;
      step(2);
      chk("lit_pause_state", state, 2);
      chk("lit_pause_presc", mp, 2);
      step(6);
      chk("lit_pause_hold", state, 2);
      start_btn = 1'b1;
      step(1);
      step(1); start_btn = 1'b0;
      step(1);
      chk("lit_resume_state", state, 1);
      step(1);
      chk("lit_resume_tick", cnt_en, 1);

      // clr and stop together during RUN
      @(posedge clk); #1 clr_btn = 1'b1; stop_btn = 1'b1;
      step(2); clr_btn = 1'b0; stop_btn = 1'b0;
      step(3);
      chk("lit_clrstop_state", state, 0);
      chk("lit_clrstop_count", count_in, 0);

      // start held 50 cycles gives one command: a stop mid-hold must stick
      @(posedge clk); #1 start_btn = 1'b1;
      step(8);
      stop_btn = 1'b1;
      step(1); stop_btn = 1'b0;
      step(41);
      chk("lit_held_start", state, 2);
      start_btn = 1'b0;
      step(4);
      chk("lit_held_release", state, 2);
      clear_all();

      // clr coincident with the terminal tick
      press_start();
      done_seen = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (ms == 1 && mc == LIMIT && mp == 1) begin ok = 1'b1; break; end
      end
      chk("wait_term_align", int'(ok), 1);
      clr_btn = 1'b1;
      step(1); clr_btn = 1'b0;
      step(4);
      chk("lit_clrterm_state", state, 0);
      chk("lit_clrterm_done_seen", int'(done_seen), 0);
      chk("lit_clrterm_count", count_in, 0);

      // asynchronous reset in the middle of RUN
      press_start();
      step(6);
      rst = 1'b0;
      #1;
      chk("lit_arst_state", state, 0);
      chk("lit_arst_running", running, 0);
      chk("lit_arst_cnt_en", cnt_en, 0);
      chk("lit_arst_cnt_clr", cnt_clr, 0);
      chk("lit_arst_done", done, 0);
      @(posedge clk); #1 rst = 1'b1;

      // random button traffic against the model
      rem_start = 0; rem_stop = 0; rem_clr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step(1);
         if (!rst) rst = 1'b1;
         else if ($urandom_range(0, 1499) == 0) rst = 1'b0;
         if (rem_start > 0) begin
            rem_start--;
            if (rem_start == 0) start_btn = 1'b0;
         end else if ($urandom_range(0, 29) == 0) begin
            start_btn = 1'b1; rem_start = int'($urandom_range(1, 6));
         end
         if (rem_stop > 0) begin
            rem_stop--;
            if (rem_stop == 0) stop_btn = 1'b0;
         end else if ($urandom_range(0, 59) == 0) begin
            stop_btn = 1'b1; rem_stop = int'($urandom_range(1, 6));
         end
         if (rem_clr > 0) begin
            rem_clr--;
            if (rem_clr == 0) clr_btn = 1'b0;
         end else if ($urandom_range(0, 149) == 0) begin
            clr_btn = 1'b1; rem_clr = int'($urandom_range(1, 6));
         end
      end
      rst = 1'b1;
      start_btn = 1'b0; stop_btn = 1'b0; clr_btn = 1'b0;
      step(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
- Run/pause/clear sequencer for the shared up-counter datapath.
- Converts three raw push-button levels into synchronized single-cycle commands.
- Generates the counter's one-cycle enable and clear strobes from an internal prescaler.
- Watches the datapath's count value to stop (or wrap) at a programmable terminal value.

Parameters:
- WIDTH, 7, width of the datapath count bus.
- TICK_DIV, 50000000, clk cycles per count increment; must be >= 2.
- LIMIT, 99, terminal count value; must be < 2^WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start_btn  in  1  raw start button level, active-high, asynchronous to clk.
- stop_btn  in  1  raw stop/pause button level, active-high, asynchronous.
- clr_btn  in  1  raw clear button level, active-high, asynchronous.
- count_in  in  WIDTH  current value fed back from the counter datapath.
- cnt_en  out  1  one-cycle increment strobe to the datapath.
- cnt_clr  out  1  one-cycle synchronous clear strobe to the datapath.
- running  out  1  high while state == RUN.
- done  out  1  high while state == DONE.
- state  out  2  current FSM state.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, prescaler = 0, sync/edge flops = 0, cnt_en = 0, cnt_clr = 0, running = 0, done = 0.
- Buttons: each goes through a 2-FF synchronizer and then a rising-edge detector.
- A button seen high before edge k acts on the FSM at edge k+2.
- One press gives one command, regardless of how long the button is held.
- States and encodings: IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3.
- Command priority within a cycle: clr > terminal tick > stop > start.
- IDLE: start -> RUN, prescaler reset to 0. clr -> stay IDLE, cnt_clr pulse.
- RUN: clr -> IDLE with cnt_clr pulse. stop -> PAUSE, prescaler held.
- PAUSE: start -> RUN, prescaler resumes from the held value. clr -> IDLE with cnt_clr pulse.
- DONE: clr -> IDLE with cnt_clr pulse. start and stop are ignored.
- Prescaler: counts 0..TICK_DIV-1 only in RUN, then wraps to 0. Cleared on every entry to IDLE.
- Tick: tick = (state == RUN) && (prescaler == TICK_DIV-1).
- cnt_en = tick && (count_in != LIMIT). It is combinational from registered state and is never high outside RUN.
- Terminal tick: tick && (count_in == LIMIT). cnt_en stays low and the next state is DONE, so the datapath holds LIMIT.
- cnt_clr: combinational, high in the cycle a clr command is accepted in any state, including IDLE.
- A clr in the same cycle as a terminal tick goes to IDLE. DONE is not entered and cnt_en stays low.
- A stop in the same cycle as a normal tick: cnt_en still pulses that cycle, and the FSM then enters PAUSE.
- running = (state == RUN); done = (state == DONE); state drives the output directly.
- Reset asserted mid-RUN: all outputs drop to 0 immediately, and no partial strobe is issued.

Optional Feature:
- Macro: COUNT_CTRL_AUTORELOAD_EN.
- Defined: a terminal tick asserts cnt_clr (not cnt_en) and the FSM stays in RUN, so the count wraps LIMIT -> 0. DONE is unreachable and done is tied to 0.
- Undefined: the terminal tick enters DONE as described above.

Decomposition:
- Package count_ctrl_pkg holds the 2-bit state encoding localparams (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE) and the command-priority ordering.
- One sub-module, btn_edge: async-reset 2-FF synchronizer plus rising-edge detector, 1-bit in and 1-cycle pulse out. It is instantiated three times.
- Prescaler and FSM stay inline.

Test Plan (TICK_DIV=4, LIMIT=5, datapath model increments on cnt_en and clears on cnt_clr):
- Reset then start press: state goes 0->1 at the 3rd edge after the press. cnt_en pulses every 4th cycle and the count goes 0,1,2,...
- Run to terminal: count reaches 5, and the next tick gives cnt_en=0 and state=3, done=1. The count holds at 5 for 20 further cycles.
- Pause/resume: stop pressed with prescaler=2 -> state 2, no cnt_en. Start -> state 1, and the next cnt_en comes 1 cycle after resume (prescaler resumed at 2).
- Held buttons: start held high for 50 cycles -> exactly one command. Start pressed in DONE -> no state change.
- Simultaneous events: clr and stop in the same sync cycle during RUN -> state 0, cnt_clr high 1 cycle, count 0. Clr coincident with the terminal tick -> state 0, done never set.
- Mid-run async reset: pulse rst low between edges -> outputs 0 immediately and state=0. With COUNT_CTRL_AUTORELOAD_EN, the terminal tick instead gives cnt_clr=1 and state stays 1.
